// File: rtl/smart_pkg.sv
// Shared types and defaults for the SmaRT throttle controller.
// The package is imported by smart_src_filter and smart_throttle_ctrl.
package smart_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ASSERT = 2'd2,
        ST_HOLD   = 2'd3
    } smart_state_t;

    localparam int SMART_FILT_CYC      = 4;
    localparam int SMART_MIN_HOLD_2MHZ = 2000;  // 1 ms at 2 MHz
    localparam int SMART_EVT_W         = 8;

    // The event counter stops at all-ones rather than wrapping, so a BMC
    // reading 255 knows that at least 255 throttle entries occurred.
    function automatic logic [SMART_EVT_W-1:0] sat_inc(input logic [SMART_EVT_W-1:0] v);
        return (v == '1) ? v : v + SMART_EVT_W'(1);
    endfunction

endpackage

// File: rtl/smart_src_filter.sv
// One throttle requester: 2-flop synchroniser followed by a stability filter.
// The filtered level is active high (1 = source is requesting throttle) and
// changes only after FILT_CYC consecutive synced samples at the new level.
module smart_src_filter
    import smart_pkg::*;
#(
    parameter int FILT_CYC = SMART_FILT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n,
    output logic filt
);

    localparam int CNT_W = $clog2(FILT_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous request into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= req_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples that disagree with the filtered level; any
    // sample that agrees again restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (~sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_CYC - 1)) begin
            filt <= ~sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smart_throttle_ctrl.sv
// SmaRT throttle arbiter: filters active-low requesters, gates them by
// enable and PWROK, and drives FM_SYS_THROTTLE (via an inverting FET) with a
// guaranteed minimum assert time. Sticky per-source flags and a saturating
// entry counter are kept for BMC readout.
// Optional build macro SMART_FORCE_THROTTLE_EN adds the iForceThrottle input,
// which forces oThrottle high while PWROK is good without touching the FSM.
module smart_throttle_ctrl
    import smart_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int FILT_CYC     = SMART_FILT_CYC,
    parameter int MIN_HOLD_CYC = SMART_MIN_HOLD_2MHZ,
    parameter int HOLD_W       = $clog2(MIN_HOLD_CYC + 1)
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iPwrOk,
    input  logic [NUM_SRC-1:0]     iSrcReq_n,
    input  logic [NUM_SRC-1:0]     iSrcEn,
    input  logic                   iStsClr,
`ifdef SMART_FORCE_THROTTLE_EN
    input  logic                   iForceThrottle,
`endif
    output logic                   oThrottle,
    output logic [NUM_SRC-1:0]     oActiveSrc,
    output logic [NUM_SRC-1:0]     oStickySts,
    output logic [SMART_EVT_W-1:0] oEventCnt
);

    logic [NUM_SRC-1:0] filt;
    logic               any_req;
    smart_state_t       state;
    smart_state_t       state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic               thr_nxt;
    logic               evt_inc;
    logic               force_on;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        smart_src_filter #(
            .FILT_CYC (FILT_CYC)
        ) u_filt (
            .clk   (iClk),
            .rst_n (iRst_n),
            .req_n (iSrcReq_n[i]),
            .filt  (filt[i])
        );
    end

    // Registered, enable-gated request level; the filters keep running when
    // a source is disabled so re-enabling takes effect on the next edge.
    always_ff @(posedge iClk) begin
        if (!iRst_n) oActiveSrc <= '0;
        else         oActiveSrc <= filt & iSrcEn;
    end

    assign any_req = |oActiveSrc;

`ifdef SMART_FORCE_THROTTLE_EN
    assign force_on = iPwrOk & iForceThrottle & (state != ST_OFF);
`else
    assign force_on = 1'b0;
`endif

    // Next state, hold counter and throttle level; PWROK loss wins over the
    // minimum hold. In ST_HOLD the output follows anyReq so release is seen
    // on the same edge that returns the FSM to ST_IDLE.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        thr_nxt   = 1'b0;
        evt_inc   = 1'b0;
        if (!iPwrOk) begin
            state_nxt = ST_OFF;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_OFF: state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (any_req) begin
                        state_nxt = ST_ASSERT;
                        hold_nxt  = HOLD_W'(MIN_HOLD_CYC - 1);
                        thr_nxt   = 1'b1;
                        evt_inc   = 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (hold_cnt == '0) begin
                        state_nxt = ST_HOLD;
                        thr_nxt   = any_req;
                    end else begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                        thr_nxt  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (any_req) thr_nxt   = 1'b1;
                    else         state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // FSM state, hold counter and the registered throttle output.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= ST_OFF;
            hold_cnt  <= '0;
            oThrottle <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            oThrottle <= thr_nxt | force_on;
        end
    end

    // Sticky flags: a source active while powered sets its flag; a set in
    // the same cycle as a clear is kept.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oStickySts <= '0;
        end else begin
            oStickySts <= (iStsClr ? '0 : oStickySts) |
                          ((state != ST_OFF) ? oActiveSrc : '0);
        end
    end

    // Throttle-entry counter; a clear coincident with an entry leaves 1.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oEventCnt <= '0;
        end else if (iStsClr) begin
            oEventCnt <= evt_inc ? SMART_EVT_W'(1) : '0;
        end else if (evt_inc) begin
            oEventCnt <= sat_inc(oEventCnt);
        end
    end

endmodule
